// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_multi
// Purpose  : N-item vending engine with per-item stock, low-stock surcharge,
//            credit overflow guard, cancel/refund and greedy 5/2/1 change.
// Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl_multi #(
   parameter int NUM_ITEMS   = 4,
   parameter int CREDIT_W    = 8,
   parameter int STOCK_W     = 4,
   parameter int MAX_CREDIT  = 99,
   parameter int INIT_STOCK  = 5,
   parameter int LOW_STOCK   = 2,
   parameter int SURCHARGE   = 1,
   parameter int ERR_CYCLES  = 1,
   parameter int AUTO_CHANGE = 1,
   localparam int ITEM_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          coin_valid,
   input  logic [CREDIT_W-1:0]           coin_value,
   input  logic                          purchase,
   input  logic                          cancel,
   input  logic [ITEM_W-1:0]             item_sel,
   input  logic [NUM_ITEMS*CREDIT_W-1:0] price_vec,
   input  logic                          restock,
   input  logic [ITEM_W-1:0]             restock_item,
   input  logic                          change_ack,
   output logic [2:0]                    state,
   output logic [CREDIT_W-1:0]           credit,
   output logic                          vend_pulse,
   output logic [ITEM_W-1:0]             vend_item,
   output logic                          change_valid,
   output logic [2:0]                    change_coin,
   output logic                          coin_reject,
   output logic                          error_flag,
   output logic [1:0]                    error_code,
   output logic [STOCK_W-1:0]            stock_level
);

   localparam int ERR_CNT_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

   localparam logic [1:0] c_ERR_FUNDS   = 2'b01;
   localparam logic [1:0] c_ERR_SOLDOUT = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_VEND   = 3'd2,
      ST_CHANGE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CREDIT_W-1:0]   r_credit, w_credit_nxt;
   logic [ITEM_W-1:0]     r_item;
   logic [STOCK_W-1:0]    r_stock [NUM_ITEMS];
   logic                  r_coin_reject;
   logic [1:0]            r_err_code, w_err_code_nxt;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   logic [STOCK_W-1:0]    w_item_stock, w_sel_stock;
   logic [CREDIT_W-1:0]   w_base_price;
   logic [CREDIT_W:0]     w_eff_price;
   logic [CREDIT_W:0]     w_coin_sum;
   logic                  w_coin_ok;
   logic [CREDIT_W-1:0]   w_vend_credit;
   logic [CREDIT_W-1:0]   w_change_amt;
   logic [CREDIT_W-1:0]   w_change_left;
   logic [2:0]            w_change_coin;
   logic                  w_change_valid;

   // Out-of-range selections read as stock 0 / price 0, so they report sold out.
   always_comb begin
      w_item_stock = '0;
      w_sel_stock  = '0;
      w_base_price = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (r_item == ITEM_W'(i)) begin
            w_item_stock = r_stock[i];
            w_base_price = price_vec[i*CREDIT_W +: CREDIT_W];
         end
         if (item_sel == ITEM_W'(i)) begin
            w_sel_stock = r_stock[i];
         end
      end
   end

   assign w_eff_price = {1'b0, w_base_price} +
                        ((w_item_stock <= STOCK_W'(LOW_STOCK)) ? (CREDIT_W+1)'(SURCHARGE) : '0);
   assign w_coin_sum  = {1'b0, r_credit} + {1'b0, coin_value};
   assign w_coin_ok   = coin_valid && (r_state == ST_IDLE) &&
                        (w_coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
   assign w_vend_credit = r_credit - w_eff_price[CREDIT_W-1:0];

   always_comb begin
      w_change_amt  = CREDIT_W'(1);
      w_change_coin = 3'b001;
      if (r_credit >= CREDIT_W'(5)) begin
         w_change_amt  = CREDIT_W'(5);
         w_change_coin = 3'b100;
      end else if (r_credit >= CREDIT_W'(2)) begin
         w_change_amt  = CREDIT_W'(2);
         w_change_coin = 3'b010;
      end
   end

   assign w_change_left  = r_credit - w_change_amt;
   assign w_change_valid = (r_state == ST_CHANGE) && (r_credit != '0);

   always_comb begin
      w_state_nxt    = r_state;
      w_credit_nxt   = w_coin_ok ? w_coin_sum[CREDIT_W-1:0] : r_credit;
      w_err_code_nxt = r_err_code;
      case (r_state)
         ST_IDLE: begin
            if (cancel && (r_credit != '0)) begin
               w_state_nxt = ST_CHANGE;
            end else if (purchase) begin
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_item_stock == '0) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = c_ERR_SOLDOUT;
            end else if ({1'b0, r_credit} < w_eff_price) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = c_ERR_FUNDS;
            end else begin
               w_state_nxt = ST_VEND;
            end
         end
         ST_VEND: begin
            w_credit_nxt = w_vend_credit;
            w_state_nxt  = ((AUTO_CHANGE != 0) && (w_vend_credit != '0)) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            if (r_credit == '0) begin
               w_state_nxt = ST_IDLE;
            end else if (change_ack) begin
               w_credit_nxt = w_change_left;
               if (w_change_left == '0) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_ERROR: begin
            if (r_err_cnt == ERR_CNT_W'(ERR_CYCLES - 1)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_credit      <= '0;
         r_item        <= '0;
         r_coin_reject <= 1'b0;
         r_err_code    <= 2'b00;
         r_err_cnt     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_credit      <= w_credit_nxt;
         r_coin_reject <= coin_valid && !w_coin_ok;
         r_err_code    <= w_err_code_nxt;
         r_err_cnt     <= (r_state == ST_ERROR) ? r_err_cnt + ERR_CNT_W'(1) : '0;
         if ((r_state == ST_IDLE) && (w_state_nxt == ST_CHECK)) begin
            r_item <= item_sel;
         end
      end
   end

   // Restock overrides a same-cycle vend decrement of the same item.
   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_stock
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_stock[g] <= STOCK_W'(INIT_STOCK);
         end else if (restock && (restock_item == ITEM_W'(g))) begin
            r_stock[g] <= STOCK_W'(INIT_STOCK);
         end else if ((r_state == ST_VEND) && (r_item == ITEM_W'(g))) begin
            r_stock[g] <= r_stock[g] - STOCK_W'(1);
         end
      end
   end

   assign state        = r_state;
   assign credit       = r_credit;
   assign vend_pulse   = (r_state == ST_VEND);
   assign vend_item    = vend_pulse ? r_item : '0;
   assign change_valid = w_change_valid;
   assign change_coin  = w_change_valid ? w_change_coin : 3'b000;
   assign coin_reject  = r_coin_reject;
   assign error_flag   = (r_state == ST_ERROR);
   assign error_code   = error_flag ? r_err_code : 2'b00;
   assign stock_level  = w_sel_stock;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_ctrl_multi
// Purpose  : Scoreboard bench for vend_ctrl_multi with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_multi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        coin_valid = 1'b0;
   logic [7:0]  coin_value = '0;
   logic        purchase = 1'b0;
   logic        cancel = 1'b0;
   logic [1:0]  item_sel = '0;
   logic [31:0] price_vec = {8'd4, 8'd6, 8'd2, 8'd3};
   logic        restock = 1'b0;
   logic [1:0]  restock_item = '0;
   logic        change_ack = 1'b0;
   logic [2:0]  state;
   logic [7:0]  credit;
   logic        vend_pulse;
   logic [1:0]  vend_item;
   logic        change_valid;
   logic [2:0]  change_coin;
   logic        coin_reject;
   logic        error_flag;
   logic [1:0]  error_code;
   logic [3:0]  stock_level;

   localparam logic [1:0] K_VEND = 2'd0, K_COIN = 2'd1, K_REJ = 2'd2, K_ERR = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [2:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   vend_ctrl_multi dut (
      .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
      .purchase(purchase), .cancel(cancel), .item_sel(item_sel), .price_vec(price_vec),
      .restock(restock), .restock_item(restock_item), .change_ack(change_ack),
      .state(state), .credit(credit), .vend_pulse(vend_pulse), .vend_item(vend_item),
      .change_valid(change_valid), .change_coin(change_coin), .coin_reject(coin_reject),
      .error_flag(error_flag), .error_code(error_code), .stock_level(stock_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic expect_ev(input logic [1:0] kind, input logic [2:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic [1:0] kind, input logic [2:0] val);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d val %0d expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         check("event", {27'd0, kind, val}, {27'd0, e.kind, e.val});
      end
   endtask

   // Monitor: every observable DUT event is matched against the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (vend_pulse)                 observe(K_VEND, {1'b0, vend_item});
         if (change_valid && change_ack) observe(K_COIN, change_coin);
         if (coin_reject)                observe(K_REJ, 3'd0);
         if (error_flag)                 observe(K_ERR, {1'b0, error_code});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic insert(input logic [7:0] v);
      coin_valid = 1'b1;
      coin_value = v;
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (state != 3'd0 && n < 100) begin
         tick();
         n++;
      end
      if (state != 3'd0) check("idle_timeout", {29'd0, state}, 32'd0);
   endtask

   task automatic buy(input logic [1:0] item);
      item_sel = item;
      purchase = 1'b1;
      tick();
      purchase = 1'b0;
      wait_idle();
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] coins [3];
      logic [7:0] left  [3];
      coins = '{3'b100, 3'b010, 3'b001};
      left  = '{8'd3, 8'd1, 8'd0};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_state", {29'd0, state}, 32'd0);
      check("reset_credit", {24'd0, credit}, 32'd0);
      check("reset_stock", {28'd0, stock_level}, 32'd5);
      check("reset_change_valid", {31'd0, change_valid}, 32'd0);
      check("reset_error_flag", {31'd0, error_flag}, 32'd0);

      // Vend item0 at price 3 from credit 5; change 2 as one coin.
      change_ack = 1'b1;
      insert(8'd5);
      check("credit_after_coin", {24'd0, credit}, 32'd5);
      expect_ev(K_VEND, 3'd0);
      expect_ev(K_COIN, 3'b010);
      buy(2'd0);
      check("credit_after_vend", {24'd0, credit}, 32'd0);
      check("stock0_after_vend", {28'd0, stock_level}, 32'd4);

      // Insufficient funds on item2 (price 6) with credit 2.
      insert(8'd2);
      expect_ev(K_ERR, 3'd1);
      item_sel = 2'd2;
      purchase = 1'b1;
      tick();
      purchase = 1'b0;
      check("state_check", {29'd0, state}, 32'd1);
      tick();
      check("state_error", {29'd0, state}, 32'd4);
      check("error_code_funds", {30'd0, error_code}, 32'd1);
      tick();
      check("state_after_error", {29'd0, state}, 32'd0);
      check("credit_kept", {24'd0, credit}, 32'd2);
      expect_ev(K_COIN, 3'b010);
      do_cancel();
      wait_idle();
      check("credit_after_refund", {24'd0, credit}, 32'd0);

      // Drain item1 (price 2, +1 surcharge at stock <= 2), then sold out.
      for (int k = 0; k < 5; k++) begin
         insert((5 - k <= 2) ? 8'd3 : 8'd2);
         expect_ev(K_VEND, 3'd1);
         buy(2'd1);
         check("stock1_drain", {28'd0, stock_level}, 32'(4 - k));
      end
      check("credit_after_drain", {24'd0, credit}, 32'd0);
      expect_ev(K_ERR, 3'd2);
      buy(2'd1);
      restock_item = 2'd1;
      restock = 1'b1;
      tick();
      restock = 1'b0;
      check("stock1_restocked", {28'd0, stock_level}, 32'd5);

      // Item0 to stock 2, then surcharge makes price 4.
      for (int k = 0; k < 2; k++) begin
         insert(8'd3);
         expect_ev(K_VEND, 3'd0);
         buy(2'd0);
      end
      check("stock0_low", {28'd0, stock_level}, 32'd2);
      insert(8'd3);
      expect_ev(K_ERR, 3'd1);
      buy(2'd0);
      check("credit_surcharge_err", {24'd0, credit}, 32'd3);
      expect_ev(K_VEND, 3'd0);
      coin_valid = 1'b1;
      coin_value = 8'd1;
      purchase   = 1'b1;
      tick();
      coin_valid = 1'b0;
      purchase   = 1'b0;
      wait_idle();
      check("credit_coin_and_buy", {24'd0, credit}, 32'd0);
      check("stock0_after_surcharge", {28'd0, stock_level}, 32'd1);

      // Credit overflow guard and coin during CHANGE.
      insert(8'd50);
      insert(8'd47);
      expect_ev(K_REJ, 3'd0);
      insert(8'd5);
      check("credit_after_reject", {24'd0, credit}, 32'd97);
      insert(8'd2);
      check("credit_at_max", {24'd0, credit}, 32'd99);
      change_ack = 1'b0;
      do_cancel();
      expect_ev(K_REJ, 3'd0);
      for (int k = 0; k < 19; k++) expect_ev(K_COIN, 3'b100);
      expect_ev(K_COIN, 3'b010);
      expect_ev(K_COIN, 3'b010);
      insert(8'd1);
      tick();
      check("credit_change_reject", {24'd0, credit}, 32'd99);
      change_ack = 1'b1;
      wait_idle();
      check("credit_after_99_refund", {24'd0, credit}, 32'd0);

      // Refund 8 with a 3-cycle delayed ack per coin.
      change_ack = 1'b0;
      insert(8'd8);
      for (int k = 0; k < 3; k++) expect_ev(K_COIN, coins[k]);
      do_cancel();
      for (int k = 0; k < 3; k++) begin
         for (int d = 0; d < 3; d++) begin
            check("coin_held", {29'd0, change_coin}, {29'd0, coins[k]});
            check("valid_held", {31'd0, change_valid}, 32'd1);
            tick();
         end
         change_ack = 1'b1;
         tick();
         change_ack = 1'b0;
         check("credit_per_coin", {24'd0, credit}, {24'd0, left[k]});
      end
      check("state_after_refund", {29'd0, state}, 32'd0);
      check("valid_after_refund", {31'd0, change_valid}, 32'd0);

      // Reset in the middle of CHANGE.
      insert(8'd8);
      do_cancel();
      tick();
      check("state_mid_change", {29'd0, state}, 32'd3);
      rst_n = 1'b0;
      #1;
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_credit", {24'd0, credit}, 32'd0);
      check("rst_change_valid", {31'd0, change_valid}, 32'd0);
      check("rst_change_coin", {29'd0, change_coin}, 32'd0);
      check("rst_strobes", {29'd0, vend_pulse, coin_reject, error_flag}, 32'd0);
      item_sel = 2'd0;
      #1;
      check("rst_stock0", {28'd0, stock_level}, 32'd5);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
